// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
// Both stages clear asynchronously while rst is low.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronizing debouncer with rise/fall pulses
// A new level at the synchronizer output is accepted after STABLE_CYCLES enabled edges.
module debounce_sync #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic en,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             accept;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (s2)
  );

  assign differ = (s2 != q);
  assign accept = differ && en && (cnt == CNT_LAST);

  // Counter only runs while the synchronized level disagrees with q; it saturates by clearing on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!differ || accept) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (accept) begin
      q <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept && s2;
      fall <= accept && !s2;
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - randomized and directed bench against a behavioural debounce model
module tb_debounce_sync;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic en  = 1'b1;
  logic q4, rise4, fall4;
  logic q1, rise1, fall1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_sync #(.STABLE_CYCLES(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .en   (en),
    .q    (q4),
    .rise (rise4),
    .fall (fall4)
  );

  debounce_sync #(.STABLE_CYCLES(1)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .en   (en),
    .q    (q1),
    .rise (rise1),
    .fall (fall1)
  );

  // Reference: din samples seen by the last two edges, then per-instance run length of disagreement.
  logic seen1, seen2;
  int   m_run  [2];
  logic m_q    [2];
  logic m_rise [2];
  logic m_fall [2];
  int   stab   [2] = '{4, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    seen1 = 1'b0;
    seen2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_q[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (!rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (seen2 == m_q[i]) begin
          m_run[i] = 0;
        end else if (en) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == stab[i]) begin
            m_q[i]    = seen2;
            m_rise[i] = seen2;
            m_fall[i] = !seen2;
            m_run[i]  = 0;
          end
        end
      end
      seen2 = seen1;
      seen1 = din;
    end
  endtask

  task automatic check_all();
    check("q4",    32'(q4),    32'(m_q[0]));
    check("rise4", 32'(rise4), 32'(m_rise[0]));
    check("fall4", 32'(fall4), 32'(m_fall[0]));
    check("cnt4",  32'(dut4.cnt), 32'(m_run[0]));
    check("q1",    32'(q1),    32'(m_q[1]));
    check("rise1", 32'(rise1), 32'(m_rise[1]));
    check("fall1", 32'(fall1), 32'(m_fall[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic settle(input logic lvl);
    din = lvl;
    en  = 1'b1;
    repeat (8) tick();
  endtask

  int n_rise, n_fall, idx;

  initial begin
    #1;
    model_reset();
    check_all();
    tick();
    tick();
    rst = 1'b1;
    repeat (3) tick();

    // clean step
    din = 1'b1;
    n_rise = 0; n_fall = 0; idx = 0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (rise4) begin n_rise++; if (idx == 0) idx = j; end
      if (fall4) n_fall++;
    end
    check("step_rise_edge", 32'(idx), 32'd6);
    check("step_rise_count", 32'(n_rise), 32'd1);
    check("step_fall_count", 32'(n_fall), 32'd0);

    // glitch of 3 cycles
    settle(1'b0);
    din = 1'b1;
    n_rise = 0;
    for (int j = 1; j <= 12; j++) begin
      if (j == 4) din = 1'b0;
      tick();
      if (rise4) n_rise++;
    end
    check("glitch_rise_count", 32'(n_rise), 32'd0);
    check("glitch_q", 32'(q4), 32'd0);
    check("glitch_cnt", 32'(dut4.cnt), 32'd0);

    // bounce 1,0,1,0,1 then hold
    din = 1'b1; tick();
    din = 1'b0; tick();
    din = 1'b1; tick();
    din = 1'b0; tick();
    din = 1'b1;
    n_rise = 0; idx = 0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (rise4) begin n_rise++; if (idx == 0) idx = j; end
    end
    check("bounce_rise_edge", 32'(idx), 32'd6);
    check("bounce_rise_count", 32'(n_rise), 32'd1);

    // enable every third cycle
    settle(1'b0);
    din = 1'b1;
    n_rise = 0; idx = 0;
    for (int j = 1; j <= 18; j++) begin
      en = (j % 3 == 1);
      tick();
      if (rise4) begin n_rise++; if (idx == 0) idx = j; end
    end
    check("gate_rise_edge", 32'(idx), 32'd13);
    check("gate_rise_count", 32'(n_rise), 32'd1);

    // async reset with cnt=2
    settle(1'b0);
    din = 1'b1;
    repeat (4) tick();
    check("mid_cnt", 32'(dut4.cnt), 32'd2);
    check("mid_q", 32'(q4), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_q4", 32'(q4), 32'd0);
    check("rst_cnt", 32'(dut4.cnt), 32'd0);
    check("rst_pulses", 32'({rise4, fall4, rise1, fall1, q1}), 32'd0);
    check_all();
    tick();
    rst = 1'b1;
    n_rise = 0; idx = 0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (rise4) begin n_rise++; if (idx == 0) idx = j; end
    end
    check("post_rst_rise_edge", 32'(idx), 32'd6);
    check("post_rst_rise_count", 32'(n_rise), 32'd1);

    // fall path on the single-cycle instance
    check("fall_pre_q1", 32'(q1), 32'd1);
    din = 1'b0;
    n_fall = 0; idx = 0;
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (fall1) begin n_fall++; if (idx == 0) idx = j; end
    end
    check("fall1_edge", 32'(idx), 32'd3);
    check("fall1_count", 32'(n_fall), 32'd1);

    // randomized runs
    for (int r = 0; r < 300; r++) begin
      int len;
      din = $urandom_range(0, 1);
      len = $urandom_range(1, 9);
      for (int j = 0; j < len; j++) begin
        en = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 150) == 0) begin
          rst = 1'b0;
          #1;
          model_reset();
          check_all();
        end else begin
          rst = 1'b1;
        end
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, the number of consecutive enabled cycles a new synchronized level must persist before acceptance (legal range 1..65535).
REQ-002 SHALL derive localparam CNT_W = $clog2(STABLE_CYCLES+1), the counter width; it is not user-settable.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port din  input  1  raw asynchronous level (switch/pin), no timing relation to clk.
REQ-006 SHALL have port en  input  1  count-enable tick; the counter advances only when en=1.
REQ-007 SHALL have port q  output  1  debounced, synchronized level, registered; this feeds a downstream D-FF d input.
REQ-008 SHALL have port rise  output  1  one-cycle registered pulse when q goes 0->1.
REQ-009 SHALL have port fall  output  1  one-cycle registered pulse when q goes 1->0.

Function
REQ-010 SHALL pass din through a two-stage synchronizer s1->s2 clocked every cycle, independent of en.
REQ-011 SHALL, each edge with s2==q, clear cnt to 0 and hold q, regardless of en.
REQ-012 SHALL, each edge with s2!=q and en=0, hold cnt and q.
REQ-013 SHALL, each edge with s2!=q, en=1, cnt<STABLE_CYCLES-1, increment cnt by 1.
REQ-014 SHALL, each edge with s2!=q, en=1, cnt==STABLE_CYCLES-1, load q<=s2, clear cnt to 0, and assert rise (if s2=1) or fall (if s2=0) on that same edge.
REQ-015 SHALL deassert rise and fall on every edge not covered by REQ-014; rise and fall are never both 1.
REQ-016 SHALL, with en tied 1, update q on the (STABLE_CYCLES+2)th rising edge after a clean din change (2 sync + STABLE_CYCLES count).
REQ-017 SHALL reject any din pulse shorter than STABLE_CYCLES enabled cycles at s2: cnt clears when s2 returns to q, q unchanged, no pulse.
REQ-018 SHALL never let cnt exceed STABLE_CYCLES-1 (no wrap-around).

Reset
REQ-019 SHALL, while rst=0, force s1, s2, q, cnt, rise, fall to 0 immediately without waiting for clk.
REQ-020 SHALL resume operation on the first rising edge with rst=1; reset deassertion is pre-synchronized to clk upstream.
REQ-021 SHALL, if din=1 at reset release, raise q with a rise pulse after STABLE_CYCLES+2 enabled edges per REQ-016.
REQ-022 SHALL abandon any in-progress count when rst asserts mid-count; no pulse is generated for it.

Structure
REQ-023 SHALL need no shared package; CNT_W is a module-local localparam.
REQ-024 SHALL place the two-flop synchronizer in sub-module sync_2ff (ports clk, rst, d, q), with reset as REQ-019.
REQ-025 SHALL keep all remaining logic (counter, q, rise/fall) in debounce_sync with one always block per register group, all reset as REQ-019.

Verification (STABLE_CYCLES=4 unless stated, en=1 unless stated)
REQ-026 SHALL check clean step: reset, din 0->1 before edge k -> q=1 and rise=1 exactly at edge k+5, rise=0 at k+6; fall stays 0.
REQ-027 SHALL check glitch: din=1 for 3 cycles then 0 -> q stays 0, rise never asserts, cnt back to 0.
REQ-028 SHALL check bounce: din toggles 1,0,1,0,1 each cycle then holds 1 -> q rises 6 edges after the final 0->1, exactly one rise pulse.
REQ-029 SHALL check enable gating: en=1 every 3rd cycle, din held 1 -> q rises after 4 enabled edges past s2 going high; no pulse before.
REQ-030 SHALL check async reset mid-count: rst=0 between edges while cnt=2 and q=0 -> all outputs 0 before the next edge; after release with din=1, q rises 6 edges later.
REQ-031 SHALL check fall path and STABLE_CYCLES=1: q=1, din->0 -> q=0 and fall=1 at the 3rd edge, one cycle only.
